// File: rtl/weight_buffer_writer.sv
// weight_buffer_writer: scatters a weight word stream into N_BUF_X x-interleaved banks
// in the same bank/address order the banked weight reader fetches from.
module weight_buffer_writer #(
    parameter int N_BUF_X    = 5,
    parameter int B_BUF_ADDR = 9,
    parameter int B_SHAPE    = 48,
    parameter int DATA_WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [B_SHAPE-1:0]             wei_shape,
    input  logic                           start,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_WIDTH-1:0]          s_data,
    output logic [N_BUF_X-1:0]             wren,
    output logic [B_BUF_ADDR*N_BUF_X-1:0]  wraddr,
    output logic [DATA_WIDTH-1:0]          wrdata,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);
    localparam int B_COORD = 8;
    localparam int B_RX    = N_BUF_X > 1 ? $clog2(N_BUF_X) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t state, state_nxt;

    logic [15:0]           w_r, h_r;
    logic [9:0]            n_r, k;
    logic [B_COORD-1:0]    x, y;
    logic [B_RX-1:0]       rx;
    logic [B_BUF_ADDR:0]   addr_r, base_r;
    logic                  load, beat, wr_ok, k_last, y_last, x_last, zero_dim;
    logic                  unused_c;

    assign unused_c = ^wei_shape[5:0];
    assign s_ready  = state == WRITE;
    assign busy     = state != IDLE;
    assign load     = state == IDLE && start;
    assign beat     = s_valid && s_ready;
    assign wr_ok    = beat && !addr_r[B_BUF_ADDR];
    assign zero_dim = wei_shape[15:6] == '0 || wei_shape[31:16] == '0 || wei_shape[47:32] == '0;
    assign k_last   = k == n_r - 10'd1;
    assign y_last   = 16'(y) == h_r - 16'd1;
    assign x_last   = 16'(x) == w_r - 16'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? (zero_dim ? DONE : WRITE) : IDLE;
            WRITE:   state_nxt = beat && k_last && y_last && x_last ? DONE : WRITE;
            default: state_nxt = IDLE;
        endcase
    end

    // k innermost, then y, then x; addr_r walks the bank linearly inside a column
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_r    <= '0;
            h_r    <= '0;
            n_r    <= '0;
            k      <= '0;
            x      <= '0;
            y      <= '0;
            rx     <= '0;
            addr_r <= '0;
            base_r <= '0;
        end else if (load) begin
            w_r    <= wei_shape[47:32];
            h_r    <= wei_shape[31:16];
            n_r    <= wei_shape[15:6];
            k      <= '0;
            x      <= '0;
            y      <= '0;
            rx     <= '0;
            addr_r <= '0;
            base_r <= '0;
        end else if (beat) begin
            if (k_last) begin
                k <= '0;
                if (y_last) begin
                    y <= '0;
                    x <= x + 1'b1;
                    // wrapping back to bank 0 opens a fresh column region after the last one
                    if (rx == B_RX'(N_BUF_X - 1)) begin
                        rx     <= '0;
                        base_r <= addr_r + 1'b1;
                        addr_r <= addr_r + 1'b1;
                    end else begin
                        rx     <= rx + 1'b1;
                        addr_r <= base_r;
                    end
                end else begin
                    y      <= y + 1'b1;
                    addr_r <= addr_r + 1'b1;
                end
            end else begin
                k      <= k + 1'b1;
                addr_r <= addr_r + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wren   <= '0;
            wraddr <= '0;
            wrdata <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done   <= state == DONE;
            wren   <= wr_ok ? N_BUF_X'(1) << rx : '0;
            wraddr <= wr_ok ? (B_BUF_ADDR*N_BUF_X)'(addr_r[B_BUF_ADDR-1:0]) << (rx * B_BUF_ADDR) : '0;
            if (beat) wrdata <= s_data;
            err    <= load ? 1'b0 : err | (beat & addr_r[B_BUF_ADDR]);
        end
    end
endmodule

// File: tb/tb_weight_buffer_writer.sv
// tb_weight_buffer_writer: directed streams with a write-log scoreboard checked
// against hand-derived bank/address expectations.
module tb_weight_buffer_writer;
    localparam int N  = 5;
    localparam int BA = 9;

    logic        clk = 0, rstn = 0, start = 0, s_valid = 0;
    logic [47:0] wei_shape = '0;
    logic [63:0] s_data = '0;
    logic        s_ready, busy, done, err;
    logic [4:0]  wren;
    logic [44:0] wraddr;
    logic [63:0] wrdata;

    weight_buffer_writer dut (
        .clk(clk), .rstn(rstn), .wei_shape(wei_shape), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    int wr_cnt, done_cnt, done_cyc, ready_cnt, shape_bad, start_cyc, first_ready;
    int wr_bank[4096], wr_addr[4096], wr_cyc[4096];
    bit wr_seen[4096];
    int mb, ma, mj;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wren != 0) begin
            mb = 0;
            for (int i = 0; i < N; i++) if (wren[i]) mb = i;
            ma = int'((wraddr >> (mb * BA)) & 45'h1ff);
            mj = int'(wrdata[11:0]);
            if (!$onehot(wren) || wraddr != (45'(ma) << (mb * BA))) shape_bad++;
            wr_seen[mj] = 1;
            wr_bank[mj] = mb;
            wr_addr[mj] = ma;
            wr_cyc[mj]  = cyc;
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (s_ready) ready_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear();
        wr_cnt = 0; done_cnt = 0; done_cyc = -1; ready_cnt = 0; shape_bad = 0;
        for (int i = 0; i < 4096; i++) wr_seen[i] = 0;
    endtask

    task automatic drive(input logic [47:0] shp, input int nb, input bit tog,
                         input int alt_at, input int stop_at);
        int j = 0, i = 0;
        bit acc, alt_done = 0;
        tick();
        wei_shape = shp;
        start = 1;
        start_cyc = cyc;
        tick();
        start = 0;
        first_ready = int'(s_ready);
        while (j < nb && j != stop_at && i < nb * 3 + 20) begin
            start = j == alt_at && !alt_done;
            if (start) begin
                wei_shape = 48'h0003_0001_0040;
                alt_done = 1;
            end else wei_shape = shp;
            s_valid = tog ? !i[0] : 1'b1;
            s_data = 64'(j);
            acc = s_valid && s_ready;
            tick();
            if (acc) j++;
            i++;
        end
        s_valid = 0;
        start = 0;
        wei_shape = shp;
        if (stop_at < 0) check("beats_accepted", 64'(j), 64'(nb));
    endtask

    task automatic wait_done();
        for (int t = 0; t < 30 && done_cnt == 0; t++) tick();
        repeat (3) tick();
    endtask

    task automatic check_map(input string tag, input int n, input int h, input int w, input int xmax);
        int x, y, k;
        for (int j = 0; j < n * h * w; j++) begin
            x = j / (h * n);
            y = (j / n) % h;
            k = j % n;
            if (x < xmax)
                check(tag, {39'd0, wr_seen[j], 8'(wr_bank[j]), 16'(wr_addr[j])},
                           {39'd0, 1'b1, 8'(x % N), 16'(n * (y + h * (x / N)) + k)});
            else
                check({tag, "_suppressed"}, 64'(wr_seen[j]), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear();
        repeat (3) tick();
        check("rst_wren", 64'(wren), 0);
        check("rst_wraddr", 64'(wraddr), 0);
        check("rst_flags", {60'd0, s_ready, busy, done, err}, 0);
        rstn = 1;
        tick();

        // contiguous stream, c=128 h=3 w=7
        clear();
        drive(48'h0007_0003_0080, 42, 0, -1, -1);
        wait_done();
        check_map("t1_map", 2, 3, 7, 99);
        check("t1_first_ready", 64'(first_ready), 1);
        check("t1_first_latency", 64'(wr_cyc[0]), 64'(start_cyc + 2));
        check("t1_j6_bank", 64'(wr_bank[6]), 1);
        check("t1_j30_addr", 64'(wr_addr[30]), 6);
        check("t1_j41_addr", 64'(wr_addr[41]), 11);
        check("t1_span", 64'(wr_cyc[41] - wr_cyc[0]), 41);
        check("t1_wr_cnt", 64'(wr_cnt), 42);
        check("t1_done_cnt", 64'(done_cnt), 1);
        check("t1_done_cyc", 64'(done_cyc), 64'(wr_cyc[41] + 1));
        check("t1_shape", 64'(shape_bad), 0);
        check("t1_end_flags", {62'd0, busy, err}, 0);

        // s_valid toggling 1010...
        clear();
        drive(48'h0007_0003_0080, 42, 1, -1, -1);
        wait_done();
        check_map("t2_map", 2, 3, 7, 99);
        check("t2_span", 64'(wr_cyc[41] - wr_cyc[0]), 82);
        check("t2_wr_cnt", 64'(wr_cnt), 42);
        check("t2_done_cyc", 64'(done_cyc), 64'(wr_cyc[41] + 1));
        check("t2_done_cnt", 64'(done_cnt), 1);

        // start pulsed mid-WRITE must be ignored
        clear();
        drive(48'h0007_0003_0080, 42, 0, 20, -1);
        wait_done();
        check_map("t6_map", 2, 3, 7, 99);
        check("t6_wr_cnt", 64'(wr_cnt), 42);
        check("t6_done_cnt", 64'(done_cnt), 1);

        // overflow: c=64 h=256 w=15, columns x>=10 land at 512+
        clear();
        drive(48'h000F_0100_0040, 3840, 0, -1, -1);
        wait_done();
        check_map("t4_map", 1, 256, 15, 10);
        check("t4_j2559_bank", 64'(wr_bank[2559]), 4);
        check("t4_j2559_addr", 64'(wr_addr[2559]), 511);
        check("t4_wr_cnt", 64'(wr_cnt), 2560);
        check("t4_err", 64'(err), 1);
        check("t4_done_cnt", 64'(done_cnt), 1);
        check("t4_shape", 64'(shape_bad), 0);

        // h=0: straight to DONE; err from previous load cleared on start
        clear();
        drive(48'h0007_0000_0080, 0, 0, -1, -1);
        wait_done();
        check("t3_done_cnt", 64'(done_cnt), 1);
        check("t3_done_cyc", 64'(done_cyc), 64'(start_cyc + 2));
        check("t3_wr_cnt", 64'(wr_cnt), 0);
        check("t3_ready_cnt", 64'(ready_cnt), 0);
        check("t3_err", 64'(err), 0);

        // reset mid-WRITE after 10 beats, then restart with c=64 h=2 w=6
        clear();
        drive(48'h0007_0003_0080, 42, 0, -1, 10);
        s_valid = 1;
        rstn = 0;
        #1;
        check("t5_rst_now", {61'd0, wren != 0, busy, s_ready}, 0);
        repeat (3) tick();
        check("t5_rst_later", {61'd0, wren != 0, busy, s_ready}, 0);
        check("t5_wr_cnt", 64'(wr_cnt), 10);
        s_valid = 0;
        rstn = 1;
        tick();
        clear();
        drive(48'h0006_0002_0040, 12, 0, -1, -1);
        wait_done();
        check_map("t5_map", 1, 2, 6, 99);
        check("t5_j10_addr", 64'(wr_addr[10]), 2);
        check("t5_wr_cnt2", 64'(wr_cnt), 12);
        check("t5_done_cnt", 64'(done_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
